// File: rtl/timer_sched.sv
// timer_sched: round-robin sequencer sharing one hull timer among N_REQ requesters.
// Optional RUN-length limit is compiled in with `define TIMER_SCHED_TIMEOUT_EN.
module timer_sched #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned BIT     = 32,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned MAX_RUN = 1000
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] stop,
  input  logic [N_REQ-1:0] dir,
  output logic             tmr_enable,
  output logic             tmr_start,
  output logic             tmr_clr_n,
  output logic             tmr_dir,
  input  logic [BIT-1:0]   tmr_count,
  output logic [N_REQ-1:0] grant,
  output logic             busy,
  output logic             done,
  output logic [ID_W-1:0]  done_id,
  output logic [BIT-1:0]   result,
  output logic             timeout
);

  if (N_REQ < 2 || N_REQ > 8 || (2 ** ID_W) < N_REQ || MAX_RUN < 1) begin : g_param_check
    $error("timer_sched: illegal parameter combination");
  end

  typedef enum logic [2:0] {StIdle, StClear, StRun, StLatch, StCapt} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic              tmr_dir_q, tmr_dir_d;
  logic              tmr_enable_q, tmr_start_q, tmr_clr_n_q, busy_q;
  logic              done_q, done_d;
  logic [ID_W-1:0]   done_id_q, done_id_d;
  logic [BIT-1:0]    result_q, result_d;
  logic              pick_found;
  logic [ID_W-1:0]   pick_idx, pick_nxt, cand_idx;
  int unsigned       cand;
  logic              run_limit;

  // First requester at or after rr_q, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_nxt   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      cand     = (32'(rr_q) + j) % N_REQ;
      cand_idx = ID_W'(cand);
      if (!pick_found && req[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
        pick_nxt   = ID_W'((cand + 1) % N_REQ);
      end
    end
  end

`ifdef TIMER_SCHED_TIMEOUT_EN
  localparam int unsigned RunW = $clog2(MAX_RUN + 1);

  logic [RunW-1:0] run_cnt_q;
  logic            to_flag_q, timeout_q;

  // run_cnt_q holds (RUN cycle number - 1) while in RUN.
  assign run_limit = (state_q == StRun) && (run_cnt_q == RunW'(MAX_RUN - 1));

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      run_cnt_q <= '0;
      to_flag_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      run_cnt_q <= (state_q == StRun) ? run_cnt_q + 1'b1 : '0;
      if (run_limit && !stop[owner_q]) begin
        to_flag_q <= 1'b1;
      end else if (state_q == StIdle) begin
        to_flag_q <= 1'b0;
      end
      timeout_q <= (state_q == StCapt) && to_flag_q;
    end
  end

  assign timeout = timeout_q;
`else
  assign run_limit = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    owner_d   = owner_q;
    grant_d   = grant_q;
    tmr_dir_d = tmr_dir_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    result_d  = result_q;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d           = StClear;
          rr_d              = pick_nxt;
          owner_d           = pick_idx;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          tmr_dir_d         = dir[pick_idx];
        end
      end
      StClear: state_d = StRun;
      StRun: begin
        if (stop[owner_q] || run_limit) begin
          state_d = StLatch;
        end
      end
      StLatch: state_d = StCapt;
      StCapt: begin
        state_d   = StIdle;
        grant_d   = '0;
        done_d    = 1'b1;
        done_id_d = owner_q;
        result_d  = tmr_count;
      end
      default: state_d = StIdle;
    endcase
  end

  // Timer pins are registered from the next state so no decode glitches reach them.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state_q      <= StIdle;
      rr_q         <= '0;
      owner_q      <= '0;
      grant_q      <= '0;
      tmr_dir_q    <= 1'b1;
      tmr_enable_q <= 1'b0;
      tmr_start_q  <= 1'b0;
      tmr_clr_n_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      done_id_q    <= '0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      owner_q      <= owner_d;
      grant_q      <= grant_d;
      tmr_dir_q    <= tmr_dir_d;
      tmr_enable_q <= (state_d == StRun);
      tmr_start_q  <= (state_d == StRun);
      tmr_clr_n_q  <= (state_d != StClear);
      busy_q       <= (state_d != StIdle);
      done_q       <= done_d;
      done_id_q    <= done_id_d;
      result_q     <= result_d;
    end
  end

  assign tmr_enable = tmr_enable_q;
  assign tmr_start  = tmr_start_q;
  assign tmr_clr_n  = tmr_clr_n_q;
  assign tmr_dir    = tmr_dir_q;
  assign grant      = grant_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign done_id    = done_id_q;
  assign result     = result_q;

endmodule

// File: tb/tb_timer_sched.sv
// Bench for timer_sched: directed vector table, corner sequences, and random traffic
// checked every cycle against an edge-timestamp reference model plus a hull timer model.
module tb_timer_sched;
  localparam int NR   = 4;
  localparam int BITW = 32;
  localparam int IDW  = 2;
  localparam int MAXR = 20;
`ifdef TIMER_SCHED_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic            Clk, Clr;
  logic [NR-1:0]   req, stop, dir;
  logic            tmr_enable, tmr_start, tmr_clr_n, tmr_dir;
  logic [BITW-1:0] tmr_count;
  logic [NR-1:0]   grant;
  logic            busy, done, timeout;
  logic [IDW-1:0]  done_id;
  logic [BITW-1:0] result;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  bit chk_on   = 1'b0;

  timer_sched #(.N_REQ(NR), .BIT(BITW), .ID_W(IDW), .MAX_RUN(MAXR)) dut (
    .Clk       (Clk),
    .Clr       (Clr),
    .req       (req),
    .stop      (stop),
    .dir       (dir),
    .tmr_enable(tmr_enable),
    .tmr_start (tmr_start),
    .tmr_clr_n (tmr_clr_n),
    .tmr_dir   (tmr_dir),
    .tmr_count (tmr_count),
    .grant     (grant),
    .busy      (busy),
    .done      (done),
    .done_id   (done_id),
    .result    (result),
    .timeout   (timeout)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // Hull timer: counts while enabled+started, latches to its output while disabled.
  logic [BITW-1:0] t_cnt;
  always @(posedge Clk or negedge tmr_clr_n) begin
    if (!tmr_clr_n) begin
      t_cnt <= '0;
    end else begin
      if (tmr_enable && tmr_start) t_cnt <= tmr_dir ? t_cnt + 1 : t_cnt - 1;
      if (!tmr_enable) tmr_count <= t_cnt;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: ages are edges since the grant edge; a stop accepted at age a
  // means a-1 RUN cycles, and done follows two edges later.
  int              m_owner, m_rr, m_age, m_stop_age;
  bit              m_timed;
  logic            e_dir, e_done, e_to;
  logic [IDW-1:0]  e_id;
  logic [BITW-1:0] e_res;

  task automatic model_reset();
    m_owner = -1; m_rr = 0; m_age = 0; m_stop_age = -1; m_timed = 1'b0;
    e_dir = 1'b1; e_done = 1'b0; e_to = 1'b0; e_id = '0; e_res = '0;
  endtask

  task automatic model_step();
    int k;
    bit found;
    e_done = 1'b0;
    e_to   = 1'b0;
    if (m_owner >= 0) begin
      m_age++;
      if (m_stop_age < 0 && m_age >= 2) begin
        if (stop[m_owner]) begin
          m_stop_age = m_age;
        end else if (TO_EN && (m_age - 1) == MAXR) begin
          m_stop_age = m_age;
          m_timed    = 1'b1;
        end
      end
      if (m_stop_age >= 0 && m_age == m_stop_age + 2) begin
        k      = m_stop_age - 1;
        e_done = 1'b1;
        e_to   = m_timed;
        e_id   = IDW'(m_owner);
        e_res  = e_dir ? 32'(k) : 32'(0 - k);
        m_owner = -1;
      end
    end else begin
      found = 1'b0;
      for (int j = 0; j < NR; j++) begin
        int c;
        c = (m_rr + j) % NR;
        if (!found && req[c]) begin
          found = 1'b1; m_owner = c; m_rr = (c + 1) % NR;
          m_age = 0; m_stop_age = -1; m_timed = 1'b0; e_dir = dir[c];
        end
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge Clk or negedge Clr);
      if (!Clr) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    logic [NR-1:0] e_grant;
    logic          e_clear, e_run;
    forever begin
      @(negedge Clk);
      #1;
      if (chk_on) begin
        e_grant = '0;
        if (m_owner >= 0) e_grant[m_owner] = 1'b1;
        e_clear = (m_owner >= 0) && (m_age == 0);
        e_run   = (m_owner >= 0) && (m_age >= 1) && (m_stop_age < 0);
        chk("grant", 32'(grant), 32'(e_grant));
        chk("busy", 32'(busy), 32'(m_owner >= 0));
        chk("tmr_clr_n", 32'(tmr_clr_n), 32'(!e_clear));
        chk("tmr_enable", 32'(tmr_enable), 32'(e_run));
        chk("tmr_start", 32'(tmr_start), 32'(e_run));
        chk("tmr_dir", 32'(tmr_dir), 32'(e_dir));
        chk("done", 32'(done), 32'(e_done));
        chk("done_id", 32'(done_id), 32'(e_id));
        chk("result", result, e_res);
        chk("timeout", 32'(timeout), 32'(e_to));
      end
    end
  end

  task automatic wait_grant(output int id, output bit ok);
    ok = 1'b0;
    id = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge Clk);
      if (grant != '0) begin
        ok = 1'b1;
        for (int b = 0; b < NR; b++) if (grant[b]) id = b;
      end
    end
    chk("grant_seen", 32'(ok), 32'd1);
  endtask

  // Optionally pulse stop for the owner, then wait (bounded) for done.
  task automatic wait_done(input bit do_stop, input int id, output int lat);
    if (do_stop) stop[id] = 1'b1;
    @(negedge Clk);
    stop = '0;
    lat  = 1;
    while (done !== 1'b1 && lat < 60) begin
      @(negedge Clk);
      lat++;
    end
    chk("done_seen", 32'(done === 1'b1), 32'd1);
  endtask

  typedef struct {
    logic [NR-1:0]   rq;
    logic [NR-1:0]   dr;
    int              k;
    int              id;
    logic [BITW-1:0] res;
  } vec_t;

  vec_t vecs[6];
  int   rr_exp[5];

  initial begin
    int id, lat, prev_done;
    vecs[0] = '{rq: 4'b0001, dr: 4'b0001, k: 10, id: 0, res: 32'd10};
    vecs[1] = '{rq: 4'b0100, dr: 4'b0000, k: 5,  id: 2, res: 32'hFFFF_FFFB};
    vecs[2] = '{rq: 4'b1000, dr: 4'b1000, k: 1,  id: 3, res: 32'd1};
    vecs[3] = '{rq: 4'b0010, dr: 4'b0000, k: 1,  id: 1, res: 32'hFFFF_FFFF};
    vecs[4] = '{rq: 4'b0001, dr: 4'b0000, k: 7,  id: 0, res: 32'hFFFF_FFF9};
    vecs[5] = '{rq: 4'b1000, dr: 4'b1000, k: 15, id: 3, res: 32'd15};
    rr_exp  = '{0, 1, 2, 3, 0};

    Clr = 1'b1; req = '0; stop = '0; dir = '0;
    #2 Clr = 1'b0;
    chk_on = 1'b1;
    repeat (2) @(negedge Clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_clr_n", 32'(tmr_clr_n), 32'd1);
    chk("rst_dir", 32'(tmr_dir), 32'd1);
    Clr = 1'b1;
    repeat (2) @(negedge Clk);

    // Directed single-requester vectors; req is dropped once granted.
    for (int v = 0; v < 6; v++) begin
      req = vecs[v].rq;
      dir = vecs[v].dr;
      wait_grant(id, chk_on);
      req = '0;
      repeat (vecs[v].k) @(negedge Clk);
      wait_done(1'b1, id, lat);
      chk("vec_latency", 32'(lat), 32'd3);
      chk("vec_id", 32'(done_id), 32'(vecs[v].id));
      chk("vec_result", result, vecs[v].res);
      chk("vec_timeout", 32'(timeout), 32'd0);
    end

    // Round robin with all requests held; each run lasts 3 cycles.
    req = 4'b1111; dir = 4'b1111; prev_done = 0;
    for (int i = 0; i < 5; i++) begin
      wait_grant(id, chk_on);
      chk("rr_order", 32'(id), 32'(rr_exp[i]));
      if (i == 4) req = '0;
      repeat (3) @(negedge Clk);
      wait_done(1'b1, id, lat);
      if (i > 0) chk("rr_gap", 32'(cyc - prev_done), 32'(3 + 4));
      prev_done = cyc;
    end

    // Stray stops: stop[0] held through CLEAR, stop[1] mid-run; only RUN stop[0] counts.
    req = 4'b0001; dir = 4'b0001;
    wait_grant(id, chk_on);
    req = '0; stop[0] = 1'b1;
    @(negedge Clk); stop = '0;
    @(negedge Clk); stop[1] = 1'b1;
    @(negedge Clk); stop = '0;
    @(negedge Clk);
    wait_done(1'b1, 0, lat);
    chk("stray_id", 32'(done_id), 32'd0);
    chk("stray_result", result, 32'd4);

    // Reset during RUN, then a clean sequence over the stale timer count.
    req = 4'b0010; dir = 4'b0010;
    wait_grant(id, chk_on);
    req = '0;
    repeat (3) @(negedge Clk);
    Clr = 1'b0;
    #1;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_grant", 32'(grant), 32'd0);
    chk("mrst_enable", 32'(tmr_enable), 32'd0);
    chk("mrst_result", result, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      chk("mrst_no_done", 32'(done), 32'd0);
    end
    Clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("mrst_idle", 32'(busy | done), 32'd0);
    end
    req = 4'b0010; dir = 4'b0010;
    wait_grant(id, chk_on);
    req = '0;
    repeat (6) @(negedge Clk);
    wait_done(1'b1, id, lat);
    chk("mrst_next_id", 32'(done_id), 32'd1);
    chk("mrst_next_result", result, 32'd6);

`ifdef TIMER_SCHED_TIMEOUT_EN
    req = 4'b0001; dir = 4'b0001;
    wait_grant(id, chk_on);
    req = '0;
    wait_done(1'b0, id, lat);
    chk("to_flag", 32'(timeout), 32'd1);
    chk("to_result", result, 32'(MAXR));
    req = 4'b0001;
    wait_grant(id, chk_on);
    req = '0;
    repeat (MAXR) @(negedge Clk);
    wait_done(1'b1, id, lat);
    chk("to_stop_wins", 32'(timeout), 32'd0);
    chk("to_stop_result", result, 32'(MAXR));
`endif

    // Random traffic; the per-cycle checker carries the comparisons.
    for (int i = 0; i < 3000; i++) begin
      @(negedge Clk);
      req  = ($urandom_range(0, 3) == 0) ? '0 : NR'($urandom);
      dir  = NR'($urandom);
      stop = NR'($urandom) & NR'($urandom) & NR'($urandom);
      Clr  = ($urandom_range(0, 399) != 0);
    end
    @(negedge Clk);
    Clr = 1'b1; req = '0; stop = '0;
    repeat (40) @(negedge Clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks,
             n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
